// File: rtl/pack_coeff_stream.sv
// Frame-level LSB-first bit-packer for Kyber ciphertext coefficients.
// Takes one D-bit coefficient per handshake and emits a little-endian byte stream.
module pack_coeff_stream #(
  parameter int KYBER_N = 256,
  parameter int KYBER_K = 2,
  parameter int i_Width = 16,
  parameter int o_Width = 8,
  parameter int D_U     = 10,
  parameter int D_V     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_Start,
  input  logic               i_Mode,
  input  logic [i_Width-1:0] i_Coeff,
  input  logic               i_Coeff_Valid,
  output logic               o_Coeff_Ready,
  output logic [o_Width-1:0] o_Byte,
  output logic               o_Byte_Valid,
  input  logic               i_Byte_Ready,
  output logic               o_Last,
  output logic               o_Busy,
  output logic               o_Done
);

  // Worst case held bits: 7 leftover + 12 new = 19.
  localparam int ACC_W = 19;
  localparam int NB_W  = 5;
  localparam int C_U   = KYBER_K * KYBER_N;
  localparam int C_V   = KYBER_N;
  localparam int CNT_W = $clog2(C_U + 1);

  localparam logic [NB_W-1:0]  D_U_W  = NB_W'(D_U);
  localparam logic [NB_W-1:0]  D_V_W  = NB_W'(D_V);
  localparam logic [ACC_W-1:0] MASK_U = ACC_W'((1 << D_U) - 1);
  localparam logic [ACC_W-1:0] MASK_V = ACC_W'((1 << D_V) - 1);
  localparam logic [CNT_W-1:0] C_U_W  = CNT_W'(C_U);
  localparam logic [CNT_W-1:0] C_V_W  = CNT_W'(C_V);
  localparam logic [NB_W-1:0]  BYTE_BITS = NB_W'(8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic             mode;
  logic [ACC_W-1:0] acc;
  logic [NB_W-1:0]  nb;
  logic [CNT_W-1:0] cnt;

  logic [NB_W-1:0]  d_sel;
  logic [ACC_W-1:0] mask_sel;
  logic [CNT_W-1:0] c_sel;
  logic [ACC_W-1:0] coeff_masked;
  logic             all_in;
  logic             coeff_fire;
  logic             byte_fire;

  assign d_sel        = mode ? D_V_W  : D_U_W;
  assign mask_sel     = mode ? MASK_V : MASK_U;
  assign c_sel        = mode ? C_V_W  : C_U_W;
  assign coeff_masked = ACC_W'(i_Coeff) & mask_sel;
  assign all_in       = (cnt == c_sel);

  assign coeff_fire = o_Coeff_Ready && i_Coeff_Valid;
  assign byte_fire  = o_Byte_Valid && i_Byte_Ready;
  assign o_Byte     = acc[o_Width-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next    = state;
    o_Coeff_Ready = 1'b0;
    o_Byte_Valid  = 1'b0;
    o_Last        = 1'b0;
    o_Busy        = 1'b0;
    o_Done        = 1'b0;
    unique case (state)
      IDLE: if (i_Start) state_next = RUN;
      RUN: begin
        o_Busy        = 1'b1;
        o_Coeff_Ready = (nb < BYTE_BITS) && !all_in;
        o_Byte_Valid  = (nb >= BYTE_BITS);
        o_Last        = o_Byte_Valid && all_in && (nb == BYTE_BITS);
        if (o_Byte_Valid && i_Byte_Ready && o_Last) state_next = DONE;
      end
      DONE: begin
        o_Busy     = 1'b1;
        o_Done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= 1'b0;
      acc  <= '0;
      nb   <= '0;
      cnt  <= '0;
    end else if (state == IDLE) begin
      if (i_Start) begin
        mode <= i_Mode;
        acc  <= '0;
        nb   <= '0;
        cnt  <= '0;
      end
    end else if (coeff_fire) begin
      acc <= acc | (coeff_masked << nb);
      nb  <= nb + d_sel;
      cnt <= cnt + CNT_W'(1);
    end else if (byte_fire) begin
      acc <= acc >> 8;
      nb  <= nb - BYTE_BITS;
    end
  end

endmodule
